// File: rtl/reg_writeback_unit_pkg.sv
// Shared constants for the register writeback unit: state encodings and parameter defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package reg_writeback_unit_pkg;

    // Default widths and load timeout
    localparam int DATA_WIDTH_DEF     = 8;
    localparam int ADDR_WIDTH_DEF     = 3;
    localparam int TIMEOUT_CYCLES_DEF = 255;

    // Kept as plain constants so the encoding stays visible in netlists and waveforms
    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] LOAD_WAIT = 1'b1;

endpackage

// File: rtl/reg_writeback_unit_if.sv
// Bundle between the datapath and the writeback unit: ALU/load requests, memory response, operand addresses, RF write port.
// Latency: n/a (wiring only).
// Backpressure: STALL is the only backpressure signal; the datapath holds fetch while it is high.
// Ports: master = datapath side (drives requests, observes RF write/STALL), slave = writeback unit.
interface reg_writeback_unit_if
    import reg_writeback_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
    logic                  ALU_WE;
    logic [ADDR_WIDTH-1:0] ALU_DEST;
    logic [DATA_WIDTH-1:0] ALU_RESULT;
    logic                  LOAD_REQ;
    logic [ADDR_WIDTH-1:0] LOAD_DEST;
    logic                  MEM_BUSYWAIT;
    logic [DATA_WIDTH-1:0] MEM_READDATA;
    logic [ADDR_WIDTH-1:0] SRC1_ADDR;
    logic [ADDR_WIDTH-1:0] SRC2_ADDR;
    logic [DATA_WIDTH-1:0] RF_IN;
    logic [ADDR_WIDTH-1:0] RF_INADDRESS;
    logic                  RF_WRITE;
    logic                  STALL;
    logic                  CONFLICT;
    logic                  TIMEOUT_ERR;

    modport master (
        output ALU_WE, ALU_DEST, ALU_RESULT, LOAD_REQ, LOAD_DEST,
               MEM_BUSYWAIT, MEM_READDATA, SRC1_ADDR, SRC2_ADDR,
        input  RF_IN, RF_INADDRESS, RF_WRITE, STALL, CONFLICT, TIMEOUT_ERR
    );

    modport slave (
        input  ALU_WE, ALU_DEST, ALU_RESULT, LOAD_REQ, LOAD_DEST,
               MEM_BUSYWAIT, MEM_READDATA, SRC1_ADDR, SRC2_ADDR,
        output RF_IN, RF_INADDRESS, RF_WRITE, STALL, CONFLICT, TIMEOUT_ERR
    );
endinterface

// File: rtl/reg_writeback_unit_wb_timeout_counter.sv
// Saturating wait-cycle counter; flags the cycle on which the next enabled count would reach the limit.
// Latency: count updates on posedge; expired is combinational from count and enable.
// Backpressure: none; clear has priority over enable.
// Ports: CLK/RESET (sync active-high), clear, enable, limit in; expired out.
module wb_timeout_counter #(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   count_inc;

    // One extra bit so the compare cannot wrap when count is all ones
    assign count_inc = {1'b0, count} + {{CNT_W{1'b0}}, 1'b1};
    assign expired   = enable && (count_inc >= {1'b0, limit});

    always_ff @(posedge CLK) begin
        if (RESET || clear) begin
            count <= '0;
        end else if (enable && (count != limit)) begin
            count <= count_inc[CNT_W-1:0];
        end
    end
endmodule

// File: rtl/reg_writeback_unit.sv
// Register-file write port driver: registers ALU results, sequences loads through memory busywait, stalls on RAW hazards.
// Latency: ALU write appears 1 cycle after acceptance; load write 1 cycle after the first non-busy posedge in LOAD_WAIT.
// Backpressure: STALL is high for all of LOAD_WAIT and in IDLE when a source operand matches the pending write.
// Ports: CLK, RESET (sync active-high), bus (slave modport of reg_writeback_unit_if).
module reg_writeback_unit
    import reg_writeback_unit_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                 CLK,
    input  logic                 RESET,
    reg_writeback_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] load_dest_q;
    logic                  cnt_clear;
    logic                  cnt_enable;
    logic                  cnt_expired;
    logic                  src_hit;

    // Counter restarts on load entry and only counts busy cycles in LOAD_WAIT
    assign cnt_clear  = (state == IDLE) && bus.LOAD_REQ;
    assign cnt_enable = (state == LOAD_WAIT) && bus.MEM_BUSYWAIT;

    wb_timeout_counter #(
        .CNT_W (CNT_W)
    ) u_timeout (
        .CLK     (CLK),
        .RESET   (RESET),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .limit   (CNT_W'(TIMEOUT_CYCLES)),
        .expired (cnt_expired)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state            <= IDLE;
            load_dest_q      <= '0;
            bus.RF_IN        <= '0;
            bus.RF_INADDRESS <= '0;
            bus.RF_WRITE     <= 1'b0;
            bus.CONFLICT     <= 1'b0;
            bus.TIMEOUT_ERR  <= 1'b0;
        end else begin
            // Write enable and conflict are single-cycle pulses
            bus.RF_WRITE <= 1'b0;
            bus.CONFLICT <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.LOAD_REQ) begin
                        // Load takes priority; a simultaneous ALU write is dropped
                        load_dest_q  <= bus.LOAD_DEST;
                        state        <= LOAD_WAIT;
                        bus.CONFLICT <= bus.ALU_WE;
                    end else if (bus.ALU_WE) begin
                        bus.RF_IN        <= bus.ALU_RESULT;
                        bus.RF_INADDRESS <= bus.ALU_DEST;
                        bus.RF_WRITE     <= 1'b1;
                    end
                end
                LOAD_WAIT: begin
                    if (!bus.MEM_BUSYWAIT) begin
                        bus.RF_IN        <= bus.MEM_READDATA;
                        bus.RF_INADDRESS <= load_dest_q;
                        bus.RF_WRITE     <= 1'b1;
                        state            <= IDLE;
                    end else if (cnt_expired) begin
                        // Abort without writing; the error stays up until reset
                        bus.TIMEOUT_ERR <= 1'b1;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // No forwarding: any read of the register being written this cycle must wait
    assign src_hit = (bus.SRC1_ADDR == bus.RF_INADDRESS) ||
                     (bus.SRC2_ADDR == bus.RF_INADDRESS);

    always_comb begin
        bus.STALL = 1'b0;
        if (state == LOAD_WAIT) begin
            bus.STALL = 1'b1;
        end else if (bus.RF_WRITE && src_hit) begin
            bus.STALL = 1'b1;
        end
    end
endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed testbench for reg_writeback_unit with TIMEOUT_CYCLES=8 and an external register-file model.
// Latency: inputs driven at negedge, outputs checked 1ns later.
// Backpressure: STALL is checked, not obeyed; stimulus is fixed per scenario.
module tb_reg_writeback_unit;
    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    logic [7:0] regs [8];

    reg_writeback_unit_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

    reg_writeback_unit #(
        .DATA_WIDTH     (8),
        .ADDR_WIDTH     (3),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file that commits the write port on each posedge
    always @(posedge clk) begin
        if (bus.RF_WRITE) regs[bus.RF_INADDRESS] <= bus.RF_IN;
    end

    task automatic idle_inputs();
        bus.ALU_WE       = 1'b0;
        bus.ALU_DEST     = 3'd0;
        bus.ALU_RESULT   = 8'h00;
        bus.LOAD_REQ     = 1'b0;
        bus.LOAD_DEST    = 3'd0;
        bus.MEM_BUSYWAIT = 1'b0;
        bus.MEM_READDATA = 8'h00;
        bus.SRC1_ADDR    = 3'd7;
        bus.SRC2_ADDR    = 3'd7;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        bus.SRC1_ADDR = 3'd0;
        bus.SRC2_ADDR = 3'd0;
        tick(); tick();
        rst = 1'b0;
        #1;
        tests_run++;
        if ({bus.RF_IN, bus.RF_INADDRESS, bus.RF_WRITE, bus.STALL, bus.CONFLICT, bus.TIMEOUT_ERR} !== 15'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h expected 0", {bus.RF_IN, bus.RF_INADDRESS, bus.RF_WRITE, bus.STALL, bus.CONFLICT, bus.TIMEOUT_ERR});
        end
        bus.SRC1_ADDR = 3'd7;
        bus.SRC2_ADDR = 3'd7;
    endtask

    task automatic test_alu_write();
        tick();
        bus.ALU_WE = 1'b1; bus.ALU_DEST = 3'd3; bus.ALU_RESULT = 8'h5A;
        #1;
        tests_run++;
        if (bus.RF_WRITE !== 1'b0) begin
            tests_failed++;
            $display("FAIL alu_write_early: RF_WRITE=%b expected 0", bus.RF_WRITE);
        end
        tick();
        bus.ALU_WE = 1'b0;
        #1;
        tests_run++;
        if (bus.RF_WRITE !== 1'b1 || bus.RF_INADDRESS !== 3'd3 || bus.RF_IN !== 8'h5A || bus.STALL !== 1'b0) begin
            tests_failed++;
            $display("FAIL alu_write: we=%b addr=%0d data=%h stall=%b expected 1/3/5a/0",
                     bus.RF_WRITE, bus.RF_INADDRESS, bus.RF_IN, bus.STALL);
        end
        tick();
        #1;
        tests_run++;
        if (bus.RF_WRITE !== 1'b0 || regs[3] !== 8'h5A) begin
            tests_failed++;
            $display("FAIL alu_commit: we=%b reg3=%h expected 0/5a", bus.RF_WRITE, regs[3]);
        end
    endtask

    task automatic test_load();
        int stall_cycles;
        stall_cycles = 0;
        tick();
        bus.LOAD_REQ = 1'b1; bus.LOAD_DEST = 3'd5; bus.MEM_BUSYWAIT = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.LOAD_REQ     = 1'b0;
            bus.MEM_BUSYWAIT = (i < 4);
            bus.MEM_READDATA = (i < 4) ? 8'h00 : 8'hC3;
            #1;
            if (bus.STALL === 1'b1 && bus.RF_WRITE === 1'b0) stall_cycles++;
        end
        tests_run++;
        if (stall_cycles != 5) begin
            tests_failed++;
            $display("FAIL load_stall_cycles: got %0d expected 5", stall_cycles);
        end
        tick();
        bus.MEM_BUSYWAIT = 1'b1;
        bus.MEM_READDATA = 8'h00;
        #1;
        tests_run++;
        if (bus.RF_WRITE !== 1'b1 || bus.RF_INADDRESS !== 3'd5 || bus.RF_IN !== 8'hC3 || bus.STALL !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_write: we=%b addr=%0d data=%h stall=%b expected 1/5/c3/0",
                     bus.RF_WRITE, bus.RF_INADDRESS, bus.RF_IN, bus.STALL);
        end
        tick();
        bus.MEM_BUSYWAIT = 1'b0;
        #1;
        tests_run++;
        if (bus.RF_WRITE !== 1'b0 || regs[5] !== 8'hC3) begin
            tests_failed++;
            $display("FAIL load_commit: we=%b reg5=%h expected 0/c3", bus.RF_WRITE, regs[5]);
        end
    endtask

    // One ALU write, then the given operand addresses in the following cycle
    task automatic hazard_case(input logic [2:0] dest, input logic [2:0] s1,
                               input logic [2:0] s2, input logic exp_stall, input string name);
        tick();
        bus.ALU_WE = 1'b1; bus.ALU_DEST = dest; bus.ALU_RESULT = 8'h11;
        bus.SRC1_ADDR = 3'd7; bus.SRC2_ADDR = 3'd7;
        tick();
        bus.ALU_WE = 1'b0; bus.SRC1_ADDR = s1; bus.SRC2_ADDR = s2;
        #1;
        tests_run++;
        if (bus.STALL !== exp_stall) begin
            tests_failed++;
            $display("FAIL %s: STALL=%b expected %b", name, bus.STALL, exp_stall);
        end
        tick();
        #1;
        tests_run++;
        if (bus.STALL !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_release: STALL=%b expected 0", name, bus.STALL);
        end
        bus.SRC1_ADDR = 3'd7; bus.SRC2_ADDR = 3'd7;
    endtask

    task automatic test_hazard();
        hazard_case(3'd2, 3'd2, 3'd6, 1'b1, "hazard_src1");
        hazard_case(3'd2, 3'd4, 3'd6, 1'b0, "hazard_none");
        hazard_case(3'd2, 3'd6, 3'd2, 1'b1, "hazard_src2");
        hazard_case(3'd0, 3'd0, 3'd6, 1'b1, "hazard_reg0");
    endtask

    task automatic test_conflict();
        regs[1] = 8'h00;
        tick();
        bus.ALU_WE = 1'b1; bus.ALU_DEST = 3'd1; bus.ALU_RESULT = 8'h77;
        bus.LOAD_REQ = 1'b1; bus.LOAD_DEST = 3'd6; bus.MEM_BUSYWAIT = 1'b0;
        bus.MEM_READDATA = 8'h99;
        tick();
        bus.ALU_WE = 1'b0; bus.LOAD_REQ = 1'b0;
        #1;
        tests_run++;
        if (bus.CONFLICT !== 1'b1 || bus.RF_WRITE !== 1'b0 || bus.STALL !== 1'b1) begin
            tests_failed++;
            $display("FAIL conflict_pulse: conflict=%b we=%b stall=%b expected 1/0/1",
                     bus.CONFLICT, bus.RF_WRITE, bus.STALL);
        end
        tick();
        #1;
        tests_run++;
        if (bus.CONFLICT !== 1'b0 || bus.RF_WRITE !== 1'b1 || bus.RF_INADDRESS !== 3'd6 || bus.RF_IN !== 8'h99) begin
            tests_failed++;
            $display("FAIL conflict_load: conflict=%b we=%b addr=%0d data=%h expected 0/1/6/99",
                     bus.CONFLICT, bus.RF_WRITE, bus.RF_INADDRESS, bus.RF_IN);
        end
        tick();
        #1;
        tests_run++;
        if (regs[1] !== 8'h00 || regs[6] !== 8'h99) begin
            tests_failed++;
            $display("FAIL conflict_regs: reg1=%h reg6=%h expected 00/99", regs[1], regs[6]);
        end
    endtask

    task automatic test_timeout();
        int bad;
        bad = 0;
        tick();
        bus.LOAD_REQ = 1'b1; bus.LOAD_DEST = 3'd7; bus.MEM_BUSYWAIT = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            bus.LOAD_REQ = 1'b0;
            #1;
            if (bus.STALL !== 1'b1 || bus.RF_WRITE !== 1'b0 || bus.TIMEOUT_ERR !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL timeout_wait: %0d bad wait cycles expected 0", bad);
        end
        tick();
        #1;
        tests_run++;
        if (bus.STALL !== 1'b0 || bus.TIMEOUT_ERR !== 1'b1 || bus.RF_WRITE !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_abort: stall=%b err=%b we=%b expected 0/1/0",
                     bus.STALL, bus.TIMEOUT_ERR, bus.RF_WRITE);
        end
        // Back in IDLE: an ALU write still works and the error stays set
        bus.ALU_WE = 1'b1; bus.ALU_DEST = 3'd4; bus.ALU_RESULT = 8'h3C;
        tick();
        bus.ALU_WE = 1'b0;
        #1;
        tests_run++;
        if (bus.TIMEOUT_ERR !== 1'b1 || bus.RF_WRITE !== 1'b1 || bus.RF_INADDRESS !== 3'd4) begin
            tests_failed++;
            $display("FAIL timeout_sticky: err=%b we=%b addr=%0d expected 1/1/4",
                     bus.TIMEOUT_ERR, bus.RF_WRITE, bus.RF_INADDRESS);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.MEM_BUSYWAIT = 1'b0;
        #1;
        tests_run++;
        if (bus.TIMEOUT_ERR !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_clear: err=%b expected 0", bus.TIMEOUT_ERR);
        end
    endtask

    task automatic test_reset_mid_load();
        regs[2] = 8'h00;
        tick();
        bus.LOAD_REQ = 1'b1; bus.LOAD_DEST = 3'd2; bus.MEM_BUSYWAIT = 1'b1;
        tick();
        bus.LOAD_REQ = 1'b0;
        tick();
        rst = 1'b1;
        bus.MEM_BUSYWAIT = 1'b0; bus.MEM_READDATA = 8'hEE;
        tick();
        rst = 1'b0;
        bus.SRC1_ADDR = 3'd0; bus.SRC2_ADDR = 3'd0;
        #1;
        tests_run++;
        if ({bus.RF_IN, bus.RF_INADDRESS, bus.RF_WRITE, bus.STALL, bus.CONFLICT, bus.TIMEOUT_ERR} !== 15'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_load: got %h expected 0", {bus.RF_IN, bus.RF_INADDRESS, bus.RF_WRITE, bus.STALL, bus.CONFLICT, bus.TIMEOUT_ERR});
        end
        tick();
        #1;
        tests_run++;
        if (bus.RF_WRITE !== 1'b0 || bus.STALL !== 1'b0 || regs[2] !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_mid_load_idle: we=%b stall=%b reg2=%h expected 0/0/00",
                     bus.RF_WRITE, bus.STALL, regs[2]);
        end
        bus.SRC1_ADDR = 3'd7; bus.SRC2_ADDR = 3'd7;
    endtask

    task automatic test_back_to_back();
        tick();
        bus.ALU_WE = 1'b1; bus.ALU_DEST = 3'd1; bus.ALU_RESULT = 8'hA1;
        tick();
        bus.ALU_DEST = 3'd6; bus.ALU_RESULT = 8'hB6;
        #1;
        tests_run++;
        if (bus.RF_WRITE !== 1'b1 || bus.RF_INADDRESS !== 3'd1 || bus.RF_IN !== 8'hA1) begin
            tests_failed++;
            $display("FAIL b2b_first: we=%b addr=%0d data=%h expected 1/1/a1",
                     bus.RF_WRITE, bus.RF_INADDRESS, bus.RF_IN);
        end
        tick();
        bus.ALU_WE = 1'b0;
        #1;
        tests_run++;
        if (bus.RF_WRITE !== 1'b1 || bus.RF_INADDRESS !== 3'd6 || bus.RF_IN !== 8'hB6) begin
            tests_failed++;
            $display("FAIL b2b_second: we=%b addr=%0d data=%h expected 1/6/b6",
                     bus.RF_WRITE, bus.RF_INADDRESS, bus.RF_IN);
        end
        tick();
        #1;
        tests_run++;
        if (bus.RF_WRITE !== 1'b0 || regs[1] !== 8'hA1 || regs[6] !== 8'hB6) begin
            tests_failed++;
            $display("FAIL b2b_commit: we=%b reg1=%h reg6=%h expected 0/a1/b6",
                     bus.RF_WRITE, regs[1], regs[6]);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        for (int i = 0; i < 8; i++) regs[i] = 8'h00;
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_alu_write();
        test_load();
        test_hazard();
        test_conflict();
        test_timeout();
        test_reset_mid_load();
        test_back_to_back();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
